maxpool_ctrl: RTL and testbench

- Sequencer in front of the maxpool engine.
- Accepts one configuration per block. Gates the upstream pixel stream into the engine and generates the 2-bit per-beat user code (index_is_not_max, index_is_max).
- Drives the engine clock-enable from downstream backpressure, then drains and reports completion via the engine's m_last.
- One instance serves all GROUPS of the engine; data bits bypass this block, and only handshakes and sideband pass through it.

---
 rtl/maxpool_ctrl_if.sv | 41 ++++
 rtl/maxpool_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_maxpool_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_ctrl_if.sv
// Handshake and sideband bundle between the maxpool sequencer and its environment.
// master: upstream/engine/downstream side; slave: the maxpool_ctrl sequencer.
interface maxpool_ctrl_if #(
  parameter int unsigned WIN_W = 4,
  parameter int unsigned CNT_W = 16
);
  // configuration
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_pool_en;
  logic [WIN_W-1:0] cfg_win_m1;
  logic [CNT_W-1:0] cfg_nwin_m1;
  // upstream pixel stream handshake
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  // engine input side
  logic             eng_valid;
  logic             eng_ready;
  logic [1:0]       eng_user;
  logic             eng_clken;
  // engine output side and downstream consumer
  logic             eng_m_valid;
  logic             eng_m_last;
  logic             dn_ready;
  // status
  logic             done;
  logic             err;

  modport master (
    output cfg_valid, cfg_pool_en, cfg_win_m1, cfg_nwin_m1,
    output in_valid, in_last, eng_ready, eng_m_valid, eng_m_last, dn_ready,
    input  cfg_ready, in_ready, eng_valid, eng_user, eng_clken, done, err
  );

  modport slave (
    input  cfg_valid, cfg_pool_en, cfg_win_m1, cfg_nwin_m1,
    input  in_valid, in_last, eng_ready, eng_m_valid, eng_m_last, dn_ready,
    output cfg_ready, in_ready, eng_valid, eng_user, eng_clken, done, err
  );
endinterface

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: per-block sequencer in front of the maxpool engine.
// Gates the upstream beat stream into the engine, generates the per-beat
// user code (bypass / window-close), drives the engine clock-enable from
// downstream backpressure and reports block completion after the engine drains.
// Optional statistics outputs are enabled by defining MAXPOOL_CTRL_STATS_EN.
module maxpool_ctrl #(
  parameter int unsigned WIN_W            = 4,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned INDEX_IS_NOT_MAX = 0,
  parameter int unsigned INDEX_IS_MAX     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  maxpool_ctrl_if.slave        bus
`ifdef MAXPOOL_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]     stat_beats,
  output logic [CNT_W-1:0]     stat_stalls
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             pool_en_q, pool_en_d;
  logic [WIN_W-1:0] win_m1_q, win_m1_d;
  logic [CNT_W-1:0] nwin_m1_q, nwin_m1_d;
  logic [WIN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             run;
  logic             cfg_acc;
  logic             fire;
  logic             win_end;
  logic             final_beat;
  logic             clken;
  logic [1:0]       user;

  // Per-cycle decode of the current beat position and handshakes
  always_comb begin
    run        = (state_q == ST_RUN) & ~reset;
    cfg_acc    = (state_q == ST_IDLE) & ~reset & bus.cfg_valid;
    fire       = run & bus.in_valid & bus.eng_ready;
    // bypass treats every beat as a complete window of length one
    win_end    = ~pool_en_q | (beat_cnt_q == win_m1_q);
    final_beat = win_end & (win_cnt_q == nwin_m1_q);
    clken      = ~reset & (bus.dn_ready | ~bus.eng_m_valid);
  end

  // Next-state and counter update
  always_comb begin
    state_d    = state_q;
    pool_en_d  = pool_en_q;
    win_m1_d   = win_m1_q;
    nwin_m1_d  = nwin_m1_q;
    beat_cnt_d = beat_cnt_q;
    win_cnt_d  = win_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          pool_en_d  = bus.cfg_pool_en;
          win_m1_d   = bus.cfg_win_m1;
          nwin_m1_d  = bus.cfg_nwin_m1;
          beat_cnt_d = '0;
          win_cnt_d  = '0;
          err_d      = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (final_beat) begin
            // counters are left alone so they never wrap past the block end
            state_d = ST_DRAIN;
            if (!bus.in_last) begin
              err_d = 1'b1;
            end
          end else if (bus.in_last) begin
            // early end-of-block: beat still goes to the engine, then drain
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else if (win_end) begin
            beat_cnt_d = '0;
            win_cnt_d  = win_cnt_q + CNT_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + WIN_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (bus.eng_m_valid && bus.eng_m_last && clken) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pool_en_q  <= 1'b0;
      win_m1_q   <= '0;
      nwin_m1_q  <= '0;
      beat_cnt_q <= '0;
      win_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pool_en_q  <= pool_en_d;
      win_m1_q   <= win_m1_d;
      nwin_m1_q  <= nwin_m1_d;
      beat_cnt_q <= beat_cnt_d;
      win_cnt_q  <= win_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Per-beat user code presented alongside eng_valid
  always_comb begin
    user                   = 2'b00;
    user[INDEX_IS_NOT_MAX] = run & ~pool_en_q;
    user[INDEX_IS_MAX]     = run & pool_en_q & (beat_cnt_q == win_m1_q);
  end

  // Pass-through handshakes add no latency on the data path
  assign bus.cfg_ready = (state_q == ST_IDLE) & ~reset;
  assign bus.in_ready  = run & bus.eng_ready;
  assign bus.eng_valid = run & bus.in_valid;
  assign bus.eng_user  = user;
  assign bus.eng_clken = clken;
  assign bus.done      = done_q & ~reset;
  assign bus.err       = err_q & ~reset;

`ifdef MAXPOOL_CTRL_STATS_EN
  logic [CNT_W-1:0] stat_beats_q, stat_beats_d;
  logic [CNT_W-1:0] stat_stalls_q, stat_stalls_d;
  logic             stall;

  // Saturating fire and stall counters, frozen while idle
  always_comb begin
    stall         = (run & bus.in_valid & ~bus.eng_ready) |
                    ((state_q != ST_IDLE) & ~reset & bus.eng_m_valid & ~bus.dn_ready);
    stat_beats_d  = stat_beats_q;
    stat_stalls_d = stat_stalls_q;
    if (cfg_acc) begin
      stat_beats_d  = '0;
      stat_stalls_d = '0;
    end else begin
      if (fire && !(&stat_beats_q)) begin
        stat_beats_d = stat_beats_q + CNT_W'(1);
      end
      if (stall && !(&stat_stalls_q)) begin
        stat_stalls_d = stat_stalls_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_beats_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_beats_q  <= stat_beats_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl: directed scenarios plus randomized blocks,
// with expected outputs derived from the block plan (beat index, window length).
module tb_maxpool_ctrl;
  localparam int unsigned WIN_W = 4;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maxpool_ctrl_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

`ifdef MAXPOOL_CTRL_STATS_EN
  logic [CNT_W-1:0] stat_beats;
  logic [CNT_W-1:0] stat_stalls;
`endif

  maxpool_ctrl #(
    .WIN_W(WIN_W), .CNT_W(CNT_W), .INDEX_IS_NOT_MAX(0), .INDEX_IS_MAX(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MAXPOOL_CTRL_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_stalls(stat_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit model_err = 1'b0;

  logic       exp_cfg_ready, exp_in_ready, exp_eng_valid, exp_clken, exp_done, exp_err;
  logic [1:0] exp_user;
  logic [1:0] fire_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, no progress within cycle budget at %0t", name, $time);
  endtask

  task automatic set_exp(input logic cr, input logic ir, input logic ev, input logic [1:0] us,
                         input logic ck, input logic dn, input logic er);
    exp_cfg_ready = cr; exp_in_ready = ir; exp_eng_valid = ev; exp_user = us;
    exp_clken = ck; exp_done = dn; exp_err = er;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_ready", 32'(bus.cfg_ready), 32'(exp_cfg_ready));
      chk("in_ready",  32'(bus.in_ready),  32'(exp_in_ready));
      chk("eng_valid", 32'(bus.eng_valid), 32'(exp_eng_valid));
      chk("eng_user",  32'(bus.eng_user),  32'(exp_user));
      chk("eng_clken", 32'(bus.eng_clken), 32'(exp_clken));
      chk("done",      32'(bus.done),      32'(exp_done));
      chk("err",       32'(bus.err),       32'(exp_err));
      if (bus.in_valid && bus.in_ready) fire_q.push_back(bus.eng_user);
    end
  end

  task automatic do_reset();
    step();
    reset = 1'b1;
    bus.cfg_valid = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1; bus.eng_ready = 1'b1;
    bus.eng_m_valid = 1'($urandom_range(0, 1)); bus.dn_ready = 1'($urandom_range(0, 1));
    set_exp(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    bus.cfg_valid = 1'b0; bus.eng_m_valid = 1'b0; bus.eng_m_last = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    model_err = 1'b0;
  endtask

  // One block: cfg accept, RUN beats, engine drain, done cycle.
  task automatic run_block(input bit pool, input int w_m1, input int n_m1, input int early_at,
                           input bit last_flag, input int unsigned iv_pct, input int unsigned er_pct,
                           input int dn_hold, input int rst_after);
    int wl, n_beats, last_idx, k, budget, cnt, delay, extra;
    bit ended;
    logic ck;
    wl = pool ? w_m1 + 1 : 1;
    n_beats = wl * (n_m1 + 1);
    last_idx = (early_at >= 0) ? early_at : (last_flag ? n_beats - 1 : -1);
    fire_q.delete();
    // configuration offer in IDLE
    step();
    bus.cfg_valid = 1'b1; bus.cfg_pool_en = pool;
    bus.cfg_win_m1 = WIN_W'(w_m1); bus.cfg_nwin_m1 = CNT_W'(n_m1);
    bus.in_valid = 1'($urandom_range(0, 1)); bus.eng_ready = 1'($urandom_range(0, 1));
    bus.in_last = 1'b0; bus.eng_m_valid = 1'b0; bus.eng_m_last = 1'b0;
    bus.dn_ready = 1'($urandom_range(0, 1));
    set_exp(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, model_err);
    model_err = 1'b0;
    // beat phase
    k = 0; ended = 1'b0; budget = 0;
    while (!ended) begin
      if (rst_after >= 0 && k == rst_after) begin
        do_reset();
        return;
      end
      step();
      bus.cfg_valid = 1'($urandom_range(0, 1));
      bus.cfg_pool_en = 1'($urandom_range(0, 1));
      bus.cfg_win_m1 = WIN_W'($urandom); bus.cfg_nwin_m1 = CNT_W'($urandom);
      bus.in_valid = ($urandom_range(0, 99) >= iv_pct);
      bus.eng_ready = ($urandom_range(0, 99) >= er_pct);
      bus.in_last = (k == last_idx);
      bus.eng_m_valid = 1'($urandom_range(0, 1)); bus.eng_m_last = 1'b0;
      bus.dn_ready = 1'($urandom_range(0, 1));
      ck = bus.dn_ready | ~bus.eng_m_valid;
      set_exp(1'b0, bus.eng_ready, bus.in_valid,
              {1'(pool && ((k % wl) == wl - 1)), 1'(!pool)}, ck, 1'b0, model_err);
      if (bus.in_valid && bus.eng_ready) begin
        if (k == n_beats - 1) begin
          ended = 1'b1;
          if (!bus.in_last) model_err = 1'b1;
        end else if (bus.in_last) begin
          ended = 1'b1;
          model_err = 1'b1;
        end
        k++;
      end
      budget++;
      if (!ended && budget > 2000) begin
        fail_timeout("run_phase");
        ended = 1'b1;
      end
    end
    // drain phase: engine emits output beats, last one closes the block
    delay = $urandom_range(0, 3); extra = $urandom_range(0, 2);
    cnt = 0; ended = 1'b0;
    while (!ended) begin
      step();
      cnt++;
      bus.cfg_valid = 1'($urandom_range(0, 1));
      bus.in_valid = 1'($urandom_range(0, 1)); bus.eng_ready = 1'($urandom_range(0, 1));
      bus.in_last = 1'($urandom_range(0, 1));
      bus.eng_m_valid = (cnt > delay);
      bus.eng_m_last = (cnt > delay + extra);
      bus.dn_ready = (cnt <= dn_hold) ? 1'b0 : 1'($urandom_range(0, 1));
      ck = bus.dn_ready | ~bus.eng_m_valid;
      set_exp(1'b0, 1'b0, 1'b0, 2'b00, ck, 1'b0, model_err);
      if (bus.eng_m_valid && bus.eng_m_last && ck) ended = 1'b1;
      if (!ended && cnt > 500) begin
        fail_timeout("drain_phase");
        ended = 1'b1;
      end
    end
    // completion cycle: done pulses, back in IDLE
    step();
    bus.cfg_valid = 1'b0; bus.in_valid = 1'($urandom_range(0, 1));
    bus.eng_m_valid = 1'b0; bus.eng_m_last = 1'b0; bus.dn_ready = 1'($urandom_range(0, 1));
    set_exp(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, model_err);
  endtask

  function automatic logic [31:0] packed_fires();
    logic [31:0] p;
    p = '0;
    foreach (fire_q[i]) p = p | (32'(fire_q[i]) << (2 * i));
    return p;
  endfunction

  initial begin
    int pool, w, n, nb, early;
    bit lf;
    reset = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_pool_en = 1'b0; bus.cfg_win_m1 = '0; bus.cfg_nwin_m1 = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.eng_ready = 1'b0;
    bus.eng_m_valid = 1'b0; bus.eng_m_last = 1'b0; bus.dn_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    // pooling 2x1 windows, 3 windows, all ready
    run_block(1'b1, 1, 2, -1, 1'b1, 0, 0, 0, -1);
    chk("pool_fires", 32'(fire_q.size()), 32'd6);
    chk("pool_pattern", packed_fires(), 32'h888);
    chk("pool_done_err", 32'(bus.err), 32'd0);

    // bypass, 4 windows; cfg_win_m1 must be ignored
    run_block(1'b0, 2, 3, -1, 1'b1, 0, 0, 0, -1);
    chk("bypass_fires", 32'(fire_q.size()), 32'd4);
    chk("bypass_pattern", packed_fires(), 32'h55);

    // early in_last on beat 3 of 6
    run_block(1'b1, 1, 2, 2, 1'b1, 0, 0, 0, -1);
    chk("early_fires", 32'(fire_q.size()), 32'd3);
    chk("early_err", 32'(bus.err), 32'd1);

    // window length 1 with pooling: every beat closes a window; clears err
    run_block(1'b1, 0, 1, -1, 1'b1, 30, 0, 0, -1);
    chk("win1_pattern", packed_fires(), 32'hA);
    chk("win1_err", 32'(bus.err), 32'd0);

    // engine backpressure, then downstream stall during drain
    run_block(1'b1, 3, 1, -1, 1'b1, 0, 50, 0, -1);
    run_block(1'b1, 1, 0, -1, 1'b1, 0, 0, 8, -1);

    // reset after two beats, then a fresh block from beat 0
    run_block(1'b1, 1, 2, -1, 1'b1, 0, 0, 0, 2);
    run_block(1'b1, 1, 2, -1, 1'b1, 0, 0, 0, -1);
    chk("post_reset_pattern", packed_fires(), 32'h888);

    // final beat without in_last flags a framing error
    run_block(1'b0, 0, 1, -1, 1'b0, 0, 0, 0, -1);
    chk("nolast_err", 32'(bus.err), 32'd1);

    // randomized blocks
    for (int i = 0; i < 40; i++) begin
      pool = $urandom_range(0, 1);
      w = $urandom_range(0, 3);
      n = $urandom_range(0, 3);
      nb = (pool != 0 ? w + 1 : 1) * (n + 1);
      early = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      lf = ($urandom_range(0, 5) != 0);
      run_block(pool != 0, w, n, early, lf, 30, 30, $urandom_range(0, 4),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1);
    end

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
